// File: rtl/axi_write_arbiter_pkg.sv
// Shared types and constants for the AXI write-port arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_RESP
  } arb_state_t;

  // Width of both the per-write cycle counter and the saturating abort counter.
  localparam int TO_CNT_W = 8;

endpackage

// File: rtl/axi_write_arbiter_rr_pick.sv
// Rotating-priority picker: the first set request after the pointer wins.
module axi_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan ptr+1 .. ptr+NUM_REQ (mod NUM_REQ) and keep the first hit.
  always_comb begin
    int c;
    c      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[c]) begin
        any       = 1'b1;
        idx       = IDX_W'(c);
        onehot[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter that shares one AXI-like write port among NUM_REQ
// requesters. The granted request is registered, held on the port until both
// the address and data channels accept, aborted after a timeout, and answered
// with a one-cycle done or err pulse to the owning requester.
module axi_write_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                             clk_domain_a,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_awaddr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_wstrb,
  output logic [NUM_REQ-1:0]               req_done,
  output logic [NUM_REQ-1:0]               req_err,
  output logic                             axi_awvalid,
  output logic [ADDR_WIDTH-1:0]            axi_awaddr,
  output logic [DATA_WIDTH-1:0]            axi_wdata,
  output logic [STRB_WIDTH-1:0]            axi_wstrb,
  input  logic                             axi_awready,
  input  logic                             axi_wready,
  output logic [IDX_W-1:0]                 grant_id,
  output logic                             busy,
  output logic [TO_CNT_W-1:0]              timeout_count
);

  // Last ISSUE cycle index before an abort; unused when the timeout is disabled.
  localparam logic [TO_CNT_W-1:0] TO_LAST =
    TO_CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  arb_state_t state, state_nxt;

  logic [IDX_W-1:0]      ptr;
  logic                  aw_seen;
  logic                  w_seen;
  logic                  err_flag;
  logic [TO_CNT_W-1:0]   to_cnt;

  logic [NUM_REQ-1:0]    pick_onehot;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [DATA_WIDTH-1:0] pick_data;
  logic [STRB_WIDTH-1:0] pick_strb;

  logic                  complete;
  logic                  expire;

  axi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req_valid),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // AND-OR select of the winning requester's payload from the one-hot grant.
  always_comb begin
    pick_addr = '0;
    pick_data = '0;
    pick_strb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) begin
        pick_addr = pick_addr | req_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        pick_data = pick_data | req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        pick_strb = pick_strb | req_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
      end
    end
  end

  // Handshake completion counts an accept in the current cycle as already seen;
  // completion takes priority over a simultaneous timeout expiry.
  always_comb begin
    complete = 1'b0;
    expire   = 1'b0;
    if (state == ARB_ISSUE) begin
      complete = (aw_seen | axi_awready) & (w_seen | axi_wready);
      expire   = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST) && !complete;
    end
  end

  // State register.
  always_ff @(posedge clk_domain_a) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: zero-strobe requests skip the port and go straight to RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_nxt = (pick_strb != '0) ? ARB_ISSUE : ARB_RESP;
        end
      end
      ARB_ISSUE: begin
        if (complete || expire) begin
          state_nxt = ARB_RESP;
        end
      end
      ARB_RESP: state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // Grant latch, handshake flags, timeout counting and round-robin pointer update.
  always_ff @(posedge clk_domain_a) begin
    if (rst) begin
      ptr           <= IDX_W'(NUM_REQ - 1);
      grant_id      <= '0;
      axi_awaddr    <= '0;
      axi_wdata     <= '0;
      axi_wstrb     <= '0;
      aw_seen       <= 1'b0;
      w_seen        <= 1'b0;
      err_flag      <= 1'b0;
      to_cnt        <= '0;
      timeout_count <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_id   <= pick_idx;
            axi_awaddr <= pick_addr;
            axi_wdata  <= pick_data;
            axi_wstrb  <= pick_strb;
          end
        end
        ARB_ISSUE: begin
          if (axi_awready) aw_seen <= 1'b1;
          if (axi_wready)  w_seen  <= 1'b1;
          to_cnt <= to_cnt + 1'b1;
          if (expire) begin
            err_flag <= 1'b1;
            if (timeout_count != '1) begin
              timeout_count <= timeout_count + 1'b1;
            end
          end
        end
        ARB_RESP: begin
          aw_seen  <= 1'b0;
          w_seen   <= 1'b0;
          err_flag <= 1'b0;
          to_cnt   <= '0;
          ptr      <= grant_id;
        end
        default: begin
          aw_seen <= 1'b0;
          w_seen  <= 1'b0;
        end
      endcase
    end
  end

  // Port valid and the per-requester response pulses decode directly from state.
  always_comb begin
    axi_awvalid = (state == ARB_ISSUE);
    busy        = (state != ARB_IDLE);
    req_done    = '0;
    req_err     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state == ARB_RESP) && (grant_id == IDX_W'(i))) begin
        req_done[i] = !err_flag;
        req_err[i]  = err_flag;
      end
    end
  end

endmodule
